// File: rtl/multiplier_datapath_taint_track_word.sv
// ---------------------------------------------------------------------------
// multiplier_datapath_taint_track_word
//
// Datapath half of a shift-and-add sequential multiplier. The control FSM
// drives the load/clear/add/shift strobes. This block holds the multiplicand
// (MD), multiplier (MR) and running-sum (RS) registers. It returns the
// multiplier register to the control so the FSM can choose add-or-skip.
//
// Every register carries one word-level taint bit. Taint is conservative: a
// tainted strobe taints every register it could have written, even when the
// strobe itself is low.
//
// Handshake: there is no valid/ready pair. Each strobe is sampled at the
// rising edge of clk and takes effect there. Outputs are pure register
// reads, so there is no combinational path from any input to any output.
//
// Ports
//   clk                   clock, rising edge
//   rst                   asynchronous, active-low reset
//   multiplicand[_t]      operand A and its taint
//   multiplier[_t]        operand B and its taint
//   mdld / mdld_t         load MD
//   mrld / mrld_t         load MR
//   rsclear / rsclear_t   clear RS
//   rsload / rsload_t     add MD into the upper half of RS
//   rsshr / rsshr_t       logical shift of RS right by one
//   multiplierReg[_t]     MR contents and its taint
//   product[_t]           RS[2*WIDTH-1:0] and the RS taint
//   illegal_op[_t]        sticky flag: more than one RS strobe in one cycle
// ---------------------------------------------------------------------------
module multiplier_datapath_taint_track_word #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic               multiplicand_t,
   input  logic [WIDTH-1:0]   multiplier,
   input  logic               multiplier_t,
   input  logic               mdld,
   input  logic               mdld_t,
   input  logic               mrld,
   input  logic               mrld_t,
   input  logic               rsclear,
   input  logic               rsclear_t,
   input  logic               rsload,
   input  logic               rsload_t,
   input  logic               rsshr,
   input  logic               rsshr_t,
   output logic [WIDTH-1:0]   multiplierReg,
   output logic               multiplierReg_t,
   output logic [2*WIDTH-1:0] product,
   output logic               product_t,
   output logic               illegal_op,
   output logic               illegal_op_t
);

   localparam int RSW = 2 * WIDTH + 1;

   // ---------------- state ----------------
   logic [WIDTH-1:0] md_q, md_d;
   logic             md_t_q, md_t_d;
   logic [WIDTH-1:0] mr_q, mr_d;
   logic             mr_t_q, mr_t_d;
   logic [RSW-1:0]   rs_q, rs_d;
   logic             rs_t_q, rs_t_d;
   logic             illegal_q, illegal_d;
   logic             illegal_t_q, illegal_t_d;

   // ---------------- helper terms ----------------
   logic             multi_strobe;  // two or more RS strobes in one cycle
   logic             rs_any_t;      // any RS strobe tainted
   logic             clean_clear;   // clear that is certain to happen
   logic [WIDTH:0]   rs_upper_sum;  // upper half plus MD, carry in MSB

   assign multi_strobe = (rsclear & rsload) | (rsclear & rsshr) | (rsload & rsshr);
   assign rs_any_t     = rsclear_t | rsload_t | rsshr_t;
   // Only an untainted clear, with no tainted competitor, can scrub RS taint.
   // A tainted load or shift might have been the real action that cycle.
   assign clean_clear  = rsclear & ~rs_any_t;
   // The add reads the registered MD. A simultaneous mdld only affects the
   // next cycle's add.
   assign rs_upper_sum = {1'b0, rs_q[2*WIDTH-1:WIDTH]} + {1'b0, md_q};

   // ---------------- MD / MR next state ----------------
   always_comb begin
      md_d   = md_q;
      md_t_d = md_t_q;
      if (mdld) begin
         md_d   = multiplicand;
         md_t_d = multiplicand_t;
      end
      // A tainted strobe might have loaded, so taint MD even when mdld is low.
      md_t_d = md_t_d | mdld_t;
   end

   always_comb begin
      mr_d   = mr_q;
      mr_t_d = mr_t_q;
      if (mrld) begin
         mr_d   = multiplier;
         mr_t_d = multiplier_t;
      end
      mr_t_d = mr_t_d | mrld_t;
   end

   // ---------------- RS next state ----------------
   // Priority order: clear, then add, then shift.
   always_comb begin
      rs_d = rs_q;
      if (rsclear) begin
         rs_d = '0;
      end else if (rsload) begin
         rs_d = {rs_upper_sum, rs_q[WIDTH-1:0]};
      end else if (rsshr) begin
         rs_d = rs_q >> 1;
      end
   end

   always_comb begin
      rs_t_d = 1'b0;
      if (!clean_clear) begin
         // A possible add pulls in the taint of MD.
         rs_t_d = rs_t_q | rs_any_t | ((rsload | rsload_t) & md_t_q);
      end
   end

   // ---------------- illegal_op ----------------
   // Sticky flag. mdld marks the start of a new operation and clears it.
   // A fresh violation in the same cycle wins over the clear.
   always_comb begin
      illegal_d   = illegal_q;
      illegal_t_d = illegal_t_q | rs_any_t | mdld_t;
      if (multi_strobe) begin
         illegal_d = 1'b1;
      end else if (mdld) begin
         illegal_d = 1'b0;
      end
      // An untainted mdld clears the taint. Any tainted RS strobe in this
      // cycle could still have set the flag, so its taint is kept.
      if (mdld && !mdld_t && !multi_strobe) begin
         illegal_t_d = rs_any_t;
      end
   end

   // ---------------- registers ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         md_q        <= '0;
         md_t_q      <= 1'b0;
         mr_q        <= '0;
         mr_t_q      <= 1'b0;
         rs_q        <= '0;
         rs_t_q      <= 1'b0;
         illegal_q   <= 1'b0;
         illegal_t_q <= 1'b0;
      end else begin
         md_q        <= md_d;
         md_t_q      <= md_t_d;
         mr_q        <= mr_d;
         mr_t_q      <= mr_t_d;
         rs_q        <= rs_d;
         rs_t_q      <= rs_t_d;
         illegal_q   <= illegal_d;
         illegal_t_q <= illegal_t_d;
      end
   end

   // ---------------- outputs ----------------
   assign multiplierReg   = mr_q;
   assign multiplierReg_t = mr_t_q;
   assign product         = rs_q[2*WIDTH-1:0];
   assign product_t       = rs_t_q;
   assign illegal_op      = illegal_q;
   assign illegal_op_t    = illegal_t_q;

endmodule

// File: tb/tb_multiplier_datapath_taint_track_word.sv
// ---------------------------------------------------------------------------
// Directed bench for multiplier_datapath_taint_track_word with WIDTH = 4.
// Inputs change 1 ns after a rising edge. Outputs are sampled 1 ns after the
// following rising edge.
// ---------------------------------------------------------------------------
module tb_multiplier_datapath_taint_track_word;

   localparam int W = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic [W-1:0]   multiplicand   = '0;
   logic           multiplicand_t = 1'b0;
   logic [W-1:0]   multiplier     = '0;
   logic           multiplier_t   = 1'b0;
   logic           mdld = 1'b0, mdld_t = 1'b0;
   logic           mrld = 1'b0, mrld_t = 1'b0;
   logic           rsclear = 1'b0, rsclear_t = 1'b0;
   logic           rsload = 1'b0, rsload_t = 1'b0;
   logic           rsshr = 1'b0, rsshr_t = 1'b0;
   logic [W-1:0]   multiplierReg;
   logic           multiplierReg_t;
   logic [2*W-1:0] product;
   logic           product_t;
   logic           illegal_op;
   logic           illegal_op_t;

   multiplier_datapath_taint_track_word #(.WIDTH(W)) dut (
      .clk             (clk),
      .rst             (rst),
      .multiplicand    (multiplicand),
      .multiplicand_t  (multiplicand_t),
      .multiplier      (multiplier),
      .multiplier_t    (multiplier_t),
      .mdld            (mdld),
      .mdld_t          (mdld_t),
      .mrld            (mrld),
      .mrld_t          (mrld_t),
      .rsclear         (rsclear),
      .rsclear_t       (rsclear_t),
      .rsload          (rsload),
      .rsload_t        (rsload_t),
      .rsshr           (rsshr),
      .rsshr_t         (rsshr_t),
      .multiplierReg   (multiplierReg),
      .multiplierReg_t (multiplierReg_t),
      .product         (product),
      .product_t       (product_t),
      .illegal_op      (illegal_op),
      .illegal_op_t    (illegal_op_t)
   );

   // ---------------- scoreboard ----------------
   logic [2*W-1:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle_strobes();
      mdld = 0; mdld_t = 0; mrld = 0; mrld_t = 0;
      rsclear = 0; rsclear_t = 0; rsload = 0; rsload_t = 0;
      rsshr = 0; rsshr_t = 0;
      multiplicand_t = 0; multiplier_t = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      idle_strobes();
   endtask

   // Full operation: load both operands with a clear, then four rounds of
   // an optional add followed by a shift. The add decision uses the bench's
   // own copy of b.
   task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic at, input logic bt);
      exp_q.push_back((2*W)'(a) * (2*W)'(b));
      multiplicand = a; multiplicand_t = at; mdld = 1;
      multiplier   = b; multiplier_t   = bt; mrld = 1;
      rsclear = 1;
      step();
      for (int i = 0; i < W; i++) begin
         if (b[i]) begin
            rsload = 1;
            step();
         end
         rsshr = 1;
         step();
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [2*W-1:0] exp_p;
      idle_strobes();

      // Reset state.
      #12;
      check("rst_product",   32'(product),         0);
      check("rst_product_t", 32'(product_t),       0);
      check("rst_mr",        32'(multiplierReg),   0);
      check("rst_illegal",   32'(illegal_op),      0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;

      // 13 x 11, untainted.
      run_mult(4'd13, 4'd11, 1'b0, 1'b0);
      exp_p = exp_q.pop_front();
      check("p13x11",         32'(product),        32'd143);
      check("p13x11_q",       32'(product),        32'(exp_p));
      check("p13x11_t",       32'(product_t),      0);
      check("p13x11_illegal", 32'(illegal_op),     0);
      check("p13x11_mr",      32'(multiplierReg),  32'd11);

      // 15 x 15: every step adds, so the carry bit is used.
      run_mult(4'hF, 4'hF, 1'b0, 1'b0);
      exp_p = exp_q.pop_front();
      check("p15x15",         32'(product),        32'd225);
      check("p15x15_q",       32'(product),        32'(exp_p));
      check("p15x15_carry",   32'(dut.rs_q[2*W]),  0);

      // Tainted multiplicand with multiplier 0: no add ever reads MD.
      run_mult(4'd9, 4'd0, 1'b1, 1'b0);
      void'(exp_q.pop_front());
      check("t0_product",     32'(product),        0);
      check("t0_md_t",        32'(dut.md_t_q),     1);
      check("t0_product_t",   32'(product_t),      0);

      // Same taint with one add: the taint reaches RS.
      run_mult(4'd5, 4'd1, 1'b1, 1'b0);
      exp_p = exp_q.pop_front();
      check("t1_product",     32'(product),        32'(exp_p));
      check("t1_product_t",   32'(product_t),      1);
      check("t1_mr_t",        32'(multiplierReg_t), 0);

      // Tainted mrld strobe that does not fire.
      multiplier = 4'd7; mrld_t = 1;
      step();
      check("mrld_t_value",   32'(multiplierReg),  32'd1);
      check("mrld_t_taint",   32'(multiplierReg_t), 1);

      // An untainted clear scrubs RS taint.
      rsclear = 1;
      step();
      check("clean_clr_p",    32'(product),        0);
      check("clean_clr_t",    32'(product_t),      0);

      // Clear and shift together: clear wins, the flag sets and holds.
      rsclear = 1; rsshr = 1;
      step();
      check("ill_rs",         32'(product),        0);
      check("ill_set",        32'(illegal_op),     1);
      check("ill_set_t",      32'(illegal_op_t),   0);
      step();
      check("ill_hold",       32'(illegal_op),     1);
      multiplicand = 4'd3; mdld = 1;
      step();
      check("ill_clr",        32'(illegal_op),     0);

      // Add and shift together, shift tainted. The add takes priority:
      // 0 + (3 << 4) = 48.
      rsload = 1; rsshr = 1; rsshr_t = 1;
      step();
      check("ill2_prio",      32'(product),        32'd48);
      check("ill2_set",       32'(illegal_op),     1);
      check("ill2_t",         32'(illegal_op_t),   1);
      check("ill2_prod_t",    32'(product_t),      1);
      multiplicand = 4'd2; mdld = 1;
      step();
      check("ill2_clr",       32'(illegal_op),     0);
      check("ill2_clr_t",     32'(illegal_op_t),   0);

      // Tainted state in the middle of an operation, then an asynchronous reset.
      multiplicand = 4'd13; multiplicand_t = 1; mdld = 1;
      multiplier = 4'd11; multiplier_t = 1; mrld = 1; rsclear = 1;
      step();
      rsload = 1;
      step();
      check("pre_rst_p",      32'(product),        32'd208);
      check("pre_rst_t",      32'(product_t),      1);
      #2 rst = 1'b0;
      #1;
      check("arst_product",   32'(product),        0);
      check("arst_mr",        32'(multiplierReg),  0);
      check("arst_mr_t",      32'(multiplierReg_t), 0);
      check("arst_prod_t",    32'(product_t),      0);
      check("arst_ill_t",     32'(illegal_op_t),   0);
      check("arst_md_t",      32'(dut.md_t_q),     0);
      @(negedge clk);
      rst = 1'b1;

      // Recovery after the reset.
      @(posedge clk); #1;
      run_mult(4'd6, 4'd7, 1'b0, 1'b0);
      exp_p = exp_q.pop_front();
      check("post_rst",       32'(product),        32'(exp_p));
      check("post_rst_t",     32'(product_t),      0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
